// File: rtl/multicycle_memory.sv
// Fixed-latency unified instruction/data memory for the multi-cycle core.
// One request at a time; completion is signalled by a one-cycle is_ready strobe.
module multicycle_memory #(
    parameter int MEM_DEPTH = 16384,
    parameter int LATENCY   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] dout,
    output logic        is_ready,
    output logic        is_busy
);

    localparam int          IW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(MEM_DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [3:0]      cnt_nxt;
    logic            accept;
    logic            access;
    logic            op_wr;
    logic [IW-1:0]   idx_q;
    logic [31:0]     din_q;
    logic [29:0]     word_mod;
    logic [31:0]     mem [MEM_DEPTH];

    // Word index wraps silently; the byte offset plays no part in addressing.
    assign word_mod = addr[31:2] % DEPTH_W;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], word_mod};

    // Next-state, counter and strobe decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        access    = 1'b0;
        is_ready  = (state == DONE);
        is_busy   = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    accept    = 1'b1;
                    cnt_nxt   = CNT_INIT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counter and read-data register; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            dout  <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (access && !op_wr) begin
                dout <= mem[idx_q];
            end
        end
    end

    // Capture the request at acceptance; a simultaneous read+write becomes a write.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            op_wr <= mem_write;
            idx_q <= word_mod[IW-1:0];
            din_q <= din;
        end
    end

    // Array commit; contents survive reset, but a pending write is dropped by it.
    always_ff @(posedge clk) begin
        if (!reset && access && op_wr) begin
            mem[idx_q] <= din_q;
        end
    end

endmodule

// File: tb/tb_multicycle_memory.sv
// Scoreboard bench for multicycle_memory (MEM_DEPTH=16, LATENCY=4).
// Expected results are queued at request time and checked at is_ready.
module tb_multicycle_memory;

    localparam int DEPTH = 16;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] din;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] dout;
    logic        is_ready;
    logic        is_busy;

    multicycle_memory #(
        .MEM_DEPTH(DEPTH),
        .LATENCY  (LAT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .dout     (dout),
        .is_ready (is_ready),
        .is_busy  (is_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errs   = 0;
    int          cyc    = 0;
    int          last_rise = 0;
    int          ready_cnt = 0;
    logic        busy_d = 1'b0;
    logic [31:0] exp_dout = 32'd0;
    logic [31:0] mdl [DEPTH];
    logic [32:0] sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    always @(posedge clk) cyc++;

    // Completion monitor: pops the scoreboard on each is_ready strobe.
    always @(negedge clk) begin
        logic [32:0] e;
        if (is_busy && !busy_d) last_rise = cyc;
        busy_d = is_busy;
        if (is_ready) begin
            ready_cnt++;
            if (sb.size() == 0) begin
                check("sb_empty_at_ready", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                if (e[32]) begin
                    exp_dout = e[31:0];
                    check("rd_dout", dout, exp_dout);
                end else begin
                    check("wr_dout_hold", dout, exp_dout);
                end
            end
        end
    end

    task automatic wait_ready(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (is_ready) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    // Issue one request from IDLE and return at the following IDLE cycle.
    task automatic req(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        din       = d;
        if (wr) begin
            mdl[widx(a)] = d;
            sb.push_back({1'b0, 32'h0});
        end else begin
            sb.push_back({1'b1, mdl[widx(a)]});
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        din       = $urandom;
        wait_ready("ready_seen");
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int rc;
        reset     = 1'b1;
        addr      = 32'd0;
        din       = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_busy", 32'(is_busy), 32'd0);
        check("rst_ready", 32'(is_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload through the write port.
        req(1'b0, 1'b1, 32'h0, 32'h0BADF00D);
        req(1'b0, 1'b1, 32'h14, 32'hDEADBEEF);

        // Read latency profile, cycle 0 = request cycle.
        mem_read = 1'b1;
        addr     = 32'h14;
        sb.push_back({1'b1, mdl[5]});
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("lat_busy_c%0d", k), 32'(is_busy),
                  32'((k >= 1) && (k <= LAT)));
            check($sformatf("lat_ready_c%0d", k), 32'(is_ready),
                  32'(k == LAT));
            if (k >= LAT) check($sformatf("lat_dout_c%0d", k), dout, 32'hDEADBEEF);
            @(posedge clk); #1;
            if (k == 0) begin
                mem_read = 1'b0;
                addr     = 32'h0;
            end
        end

        // Write then read back, spaced LATENCY+1 cycles.
        req(1'b0, 1'b1, 32'h20, 32'h12345678);
        w = last_rise;
        req(1'b1, 1'b0, 32'h20, 32'h0);
        check("spacing", 32'(last_rise - w), 32'(LAT + 1));

        // Simultaneous read+write is a write; dout holds.
        req(1'b1, 1'b1, 32'h8, 32'hA5A5A5A5);
        check("rw_dout_hold", dout, 32'h12345678);
        req(1'b1, 1'b0, 32'h8, 32'h0);

        // Second request during WAIT is ignored.
        rc        = ready_cnt;
        mem_read  = 1'b1;
        addr      = 32'h14;
        sb.push_back({1'b1, mdl[5]});
        @(posedge clk); #1;
        addr = 32'h40;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_read = 1'b0;
        wait_ready("ign_ready_seen");
        repeat (8) @(negedge clk);
        check("ign_pulses", 32'(ready_cnt - rc), 32'd1);
        check("ign_dout", dout, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset two cycles after accepting a write.
        rc        = ready_cnt;
        mem_write = 1'b1;
        addr      = 32'h0;
        din       = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        exp_dout = 32'd0;
        check("mrst_dout", dout, 32'd0);
        check("mrst_busy", 32'(is_busy), 32'd0);
        check("mrst_ready", 32'(is_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("mrst_no_ready", 32'(ready_cnt - rc), 32'd0);
        @(posedge clk); #1;
        req(1'b1, 1'b0, 32'h0, 32'h0);

        // Reset and request in the same cycle: reset wins.
        rc       = ready_cnt;
        reset    = 1'b1;
        mem_read = 1'b1;
        addr     = 32'h14;
        @(posedge clk); #1;
        reset    = 1'b0;
        mem_read = 1'b0;
        check("rreq_busy", 32'(is_busy), 32'd0);
        repeat (6) @(negedge clk);
        check("rreq_no_ready", 32'(ready_cnt - rc), 32'd0);
        check("rreq_dout", dout, 32'd0);
        @(posedge clk); #1;

        // Wrapped, unaligned address maps back to word 0.
        req(1'b1, 1'b0, 32'h43, 32'h0);
        check("wrap_dout", dout, 32'h0BADF00D);

        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
